// File: rtl/sh7604_dreq_target.sv
// sh7604_dreq_target: SH7604 DMAC slave with DREQ pacing, wait-state beats and source/sink FIFOs
module sh7604_dreq_target #(
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int DEPTH = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [31:0] BUS_A,
  input  logic [31:0] BUS_DI,
  output logic [31:0] BUS_DO,
  input  logic [3:0]  BUS_BA,
  input  logic        BUS_WE,
  input  logic        BUS_REQ,
  input  logic        BUS_BURST,
  output logic        BUS_WAIT,
  output logic        DREQ,
  input  logic        DACK,
  input  logic [31:0] SRC_DATA,
  input  logic        SRC_WR,
  output logic        SRC_FULL,
  output logic [31:0] SNK_DATA,
  input  logic        SNK_RD,
  output logic        SNK_EMPTY
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAITING, BURST} state_t;
  state_t st_q, st_d;
  logic [2:0] cnt_q, cnt_d, ctrl_q, ctrl_d;
  logic [AW-1:0] src_rp_q, src_rp_d, src_wp_q, src_wp_d, snk_rp_q, snk_rp_d, snk_wp_q, snk_wp_d;
  logic [LW-1:0] src_lvl_q, src_lvl_d, snk_lvl_q, snk_lvl_d, thr, snk_free;
  logic unf_q, unf_d, ovf_q, ovf_d, gap_q, gap_d;
  logic [31:0] src_mem [DEPTH];
  logic [31:0] snk_mem [DEPTH];
  logic sel, done, rd_data, wr_data, wr_ctrl, clr, src_empty, snk_full;
  logic src_pop, src_push, snk_pop, snk_push;
  logic [1:0] off;
  logic [31:0] lane_mask, stat;
  logic unused_ok;
  assign unused_ok = ^BUS_A[1:0];
  always_comb begin
    sel = BUS_REQ & (BUS_A[31:4] == BASE[31:4]);
    off = BUS_A[3:2];
    BUS_WAIT = sel & ((st_q == IDLE & WAIT_CYC != 0) | (st_q == WAITING & cnt_q != 0));
    done = CE & sel & ~BUS_WAIT;
    rd_data = done & ~BUS_WE & off == 2'd0;
    wr_data = done & BUS_WE & off == 2'd1;
    wr_ctrl = done & BUS_WE & off == 2'd3 & BUS_BA[0];
    clr = wr_ctrl & BUS_DI[3];
    src_empty = src_lvl_q == '0;
    snk_full = snk_lvl_q == LW'(DEPTH);
    src_pop = rd_data & ~src_empty;
    src_push = CE & SRC_WR & (~SRC_FULL | src_pop);
    snk_push = wr_data & ~snk_full;
    snk_pop = CE & SNK_RD & ~SNK_EMPTY;
    lane_mask = {{8{BUS_BA[3]}}, {8{BUS_BA[2]}}, {8{BUS_BA[1]}}, {8{BUS_BA[0]}}};
    // Burst beats stay zero-wait until the master drops its request
    st_d = ~CE ? st_q : ~sel ? IDLE : done ? ((BUS_BURST | st_q == BURST) ? BURST : IDLE) : WAITING;
    // IDLE already spends one stalled cycle, so the counter covers the rest
    cnt_d = ~CE ? cnt_q : st_q == IDLE ? 3'(WAIT_CYC - 1) : cnt_q - 3'(cnt_q != 3'd0);
    src_rp_d = src_rp_q + AW'(src_pop);
    src_wp_d = src_wp_q + AW'(src_push);
    snk_rp_d = snk_rp_q + AW'(snk_pop);
    snk_wp_d = snk_wp_q + AW'(snk_push);
    src_lvl_d = src_lvl_q + LW'(src_push) - LW'(src_pop);
    snk_lvl_d = snk_lvl_q + LW'(snk_push) - LW'(snk_pop);
    ctrl_d = wr_ctrl ? BUS_DI[2:0] : ctrl_q;
    unf_d = (rd_data & src_empty) | (unf_q & ~clr);
    ovf_d = (wr_data & snk_full) | (ovf_q & ~clr);
    gap_d = CE ? (rd_data | wr_data) & DACK : gap_q;
    thr = ctrl_q[2] ? LW'(4) : LW'(1);
    snk_free = LW'(DEPTH) - snk_lvl_q;
    DREQ = ~(ctrl_q[1] & ~gap_q & (ctrl_q[0] ? snk_free >= thr : src_lvl_q >= thr));
    stat = {16'h0, ovf_q, unf_q, 2'b0, 6'(snk_lvl_q), 6'(src_lvl_q)};
    BUS_DO = ~sel ? 32'h0 : off == 2'd0 ? (src_empty ? 32'h0 : src_mem[src_rp_q]) :
             off == 2'd2 ? stat : off == 2'd3 ? {29'h0, ctrl_q} : 32'h0;
    SRC_FULL = src_lvl_q == LW'(DEPTH);
    SNK_EMPTY = snk_lvl_q == '0;
    SNK_DATA = snk_mem[snk_rp_q];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q <= IDLE;
      cnt_q <= '0;
      ctrl_q <= '0;
      src_rp_q <= '0;
      src_wp_q <= '0;
      snk_rp_q <= '0;
      snk_wp_q <= '0;
      src_lvl_q <= '0;
      snk_lvl_q <= '0;
      unf_q <= 1'b0;
      ovf_q <= 1'b0;
      gap_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      ctrl_q <= ctrl_d;
      src_rp_q <= src_rp_d;
      src_wp_q <= src_wp_d;
      snk_rp_q <= snk_rp_d;
      snk_wp_q <= snk_wp_d;
      src_lvl_q <= src_lvl_d;
      snk_lvl_q <= snk_lvl_d;
      unf_q <= unf_d;
      ovf_q <= ovf_d;
      gap_q <= gap_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (src_push & ~RST) src_mem[src_wp_q] <= SRC_DATA;
    if (snk_push & ~RST) snk_mem[snk_wp_q] <= BUS_DI & lane_mask;
  end
endmodule

// File: tb/tb_sh7604_dreq_target.sv
// tb_sh7604_dreq_target: directed and randomized checks against a queue-based model
module tb_sh7604_dreq_target;
  localparam logic [31:0] BASE = 32'h2600_0040;
  localparam int DEPTH = 8;
  localparam int WC = 2;
  logic CLK = 1'b0, RST = 1'b1, CE = 1'b1;
  logic BUS_WE = 1'b0, BUS_REQ = 1'b0, BUS_BURST = 1'b0, DACK = 1'b0, SRC_WR = 1'b0, SNK_RD = 1'b0;
  logic [31:0] BUS_A = '0, BUS_DI = '0, SRC_DATA = '0;
  logic [3:0] BUS_BA = '0;
  logic [31:0] BUS_DO, SNK_DATA;
  logic BUS_WAIT, DREQ, SRC_FULL, SNK_EMPTY;
  int n_chk = 0, n_fail = 0;
  bit ce_rand = 1'b0;
  logic [31:0] mq_src[$];
  logic [31:0] mq_snk[$];
  logic [2:0] m_ctrl = '0;
  bit m_unf, m_ovf, m_gap;

  sh7604_dreq_target #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYC(WC)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .BUS_A(BUS_A), .BUS_DI(BUS_DI), .BUS_DO(BUS_DO),
    .BUS_BA(BUS_BA), .BUS_WE(BUS_WE), .BUS_REQ(BUS_REQ), .BUS_BURST(BUS_BURST),
    .BUS_WAIT(BUS_WAIT), .DREQ(DREQ), .DACK(DACK), .SRC_DATA(SRC_DATA), .SRC_WR(SRC_WR),
    .SRC_FULL(SRC_FULL), .SNK_DATA(SNK_DATA), .SNK_RD(SNK_RD), .SNK_EMPTY(SNK_EMPTY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_dreq();
    int thr;
    bit ok;
    thr = m_ctrl[2] ? 4 : 1;
    ok = m_ctrl[0] ? (DEPTH - mq_snk.size()) >= thr : mq_src.size() >= thr;
    return !(m_ctrl[1] && !m_gap && ok);
  endfunction

  function automatic logic [31:0] exp_reg(input logic [1:0] off);
    if (off == 2'd2) return {16'h0, m_ovf, m_unf, 2'b0, 6'(mq_snk.size()), 6'(mq_src.size())};
    if (off == 2'd3) return {29'h0, m_ctrl};
    return 32'h0;
  endfunction

  task automatic check_static();
    check("dreq", DREQ, exp_dreq());
    check("src_full", SRC_FULL, mq_src.size() == DEPTH);
    check("snk_empty", SNK_EMPTY, mq_snk.size() == 0);
    if (mq_snk.size() != 0) check("snk_data", SNK_DATA, mq_snk[0]);
  endtask

  task automatic tick(input bit done);
    bit rd, wr, snk_was_empty;
    logic [31:0] m;
    rd = done && !BUS_WE && BUS_A[3:2] == 2'd0;
    wr = done && BUS_WE && BUS_A[3:2] == 2'd1;
    snk_was_empty = mq_snk.size() == 0;
    if (RST) begin
      mq_src.delete();
      mq_snk.delete();
      m_ctrl = '0;
      m_unf = 0;
      m_ovf = 0;
      m_gap = 0;
    end else if (CE) begin
      if (rd) begin
        if (mq_src.size() != 0) void'(mq_src.pop_front());
        else m_unf = 1;
      end
      if (wr) begin
        m = BUS_DI;
        for (int i = 0; i < 4; i++) if (!BUS_BA[i]) m[i*8 +: 8] = 8'h0;
        if (mq_snk.size() < DEPTH) mq_snk.push_back(m);
        else m_ovf = 1;
      end
      if (done && BUS_WE && BUS_A[3:2] == 2'd3 && BUS_BA[0]) begin
        m_ctrl = BUS_DI[2:0];
        if (BUS_DI[3]) begin
          m_unf = 0;
          m_ovf = 0;
        end
      end
      m_gap = (rd || wr) && DACK;
      if (SRC_WR && mq_src.size() < DEPTH) mq_src.push_back(SRC_DATA);
      if (SNK_RD && !snk_was_empty) void'(mq_snk.pop_front());
    end
    @(posedge CLK);
    #1;
    CE = ce_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    check_static();
    tick(0);
  endtask

  task automatic push_src(input logic [31:0] d);
    SRC_WR = 1'b1;
    SRC_DATA = d;
    idle_cycle();
    SRC_WR = 1'b0;
  endtask

  task automatic pop_snk();
    SNK_RD = 1'b1;
    idle_cycle();
    SNK_RD = 1'b0;
  endtask

  task automatic access(input logic [1:0] off, input logic we, input logic [31:0] wd,
                        input logic [3:0] ba, input int beats, input logic dack);
    int rem, guard;
    bit ce_was;
    BUS_REQ = 1'b1;
    BUS_A = BASE | {28'h0, off, 2'b00};
    BUS_WE = we;
    BUS_BA = ba;
    BUS_BURST = beats > 1;
    DACK = dack;
    for (int b = 0; b < beats; b++) begin
      BUS_DI = (b == 0) ? wd : $urandom;
      rem = (b == 0) ? WC : 0;
      guard = 0;
      forever begin
        @(negedge CLK);
        check_static();
        check("bus_wait", BUS_WAIT, rem > 0);
        guard++;
        if (guard > 60) begin
          check("beat_timeout", guard, 0);
          break;
        end
        if (rem > 0) begin
          if (CE) rem--;
          tick(0);
        end else begin
          if (!we && off == 2'd0) check("rd_data", BUS_DO, mq_src.size() != 0 ? mq_src[0] : 32'h0);
          else if (!we) check("rd_reg", BUS_DO, exp_reg(off));
          ce_was = CE;
          tick(1);
          if (ce_was) break;
        end
      end
    end
    BUS_REQ = 1'b0;
    BUS_BURST = 1'b0;
    BUS_WE = 1'b0;
    DACK = 1'b0;
    do begin
      ce_was = CE;
      @(negedge CLK);
      check_static();
      check("wait_idle", BUS_WAIT, 0);
      check("do_idle", BUS_DO, 0);
      tick(0);
    end while (!ce_was);
  endtask

  task automatic miss();
    BUS_REQ = 1'b1;
    BUS_A = BASE ^ 32'h0000_1000;
    BUS_WE = 1'($urandom);
    @(negedge CLK);
    check_static();
    check("miss_wait", BUS_WAIT, 0);
    check("miss_do", BUS_DO, 0);
    tick(0);
    BUS_REQ = 1'b0;
    BUS_WE = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    tick(0);
    tick(0);
    RST = 1'b0;
    @(negedge CLK);
    check_static();
    check("rst_wait", BUS_WAIT, 0);
    check("rst_do", BUS_DO, 0);
    check("rst_dreq", DREQ, 1);
    check("rst_snk_empty", SNK_EMPTY, 1);
    tick(0);
    push_src(32'h1111_1111);
    push_src(32'h2222_2222);
    access(2'd3, 1, 32'h2, 4'hf, 1, 0);
    @(negedge CLK);
    check("dreq_armed", DREQ, 0);
    tick(0);
    access(2'd0, 0, 0, 4'hf, 1, 1);
    @(negedge CLK);
    check("dreq_rearmed", DREQ, 0);
    tick(0);
    access(2'd2, 0, 0, 4'hf, 1, 0);
    access(2'd0, 0, 0, 4'hf, 1, 0);
    access(2'd3, 1, 32'h6, 4'hf, 1, 0);
    repeat (3) push_src($urandom);
    @(negedge CLK);
    check("dreq_bm3", DREQ, 1);
    tick(0);
    push_src($urandom);
    @(negedge CLK);
    check("dreq_bm4", DREQ, 0);
    tick(0);
    access(2'd0, 0, 0, 4'hf, 4, 1);
    access(2'd2, 0, 0, 4'hf, 1, 0);
    access(2'd3, 1, 32'h3, 4'hf, 1, 0);
    access(2'd1, 1, 32'hAABB_CCDD, 4'b0011, 1, 0);
    @(negedge CLK);
    check("snk_mask", SNK_DATA, 32'h0000_CCDD);
    check("snk_not_empty", SNK_EMPTY, 0);
    tick(0);
    repeat (7) access(2'd1, 1, $urandom, 4'hf, 1, 0);
    access(2'd1, 1, 32'hDEAD_BEEF, 4'hf, 1, 0);
    access(2'd2, 0, 0, 4'hf, 1, 0);
    access(2'd3, 1, 32'hB, 4'hf, 1, 0);
    access(2'd2, 0, 0, 4'hf, 1, 0);
    access(2'd0, 0, 0, 4'hf, 1, 0);
    access(2'd2, 0, 0, 4'hf, 1, 0);
    repeat (DEPTH) push_src($urandom);
    SRC_WR = 1'b1;
    SRC_DATA = 32'h5A5A_5A5A;
    access(2'd0, 0, 0, 4'hf, 1, 0);
    SRC_WR = 1'b0;
    @(negedge CLK);
    check("src_full_kept", SRC_FULL, 1);
    tick(0);
    access(2'd2, 0, 0, 4'hf, 1, 0);
    BUS_REQ = 1'b1;
    BUS_A = BASE;
    BUS_WE = 1'b0;
    @(negedge CLK);
    check("pre_rst_wait", BUS_WAIT, 1);
    tick(0);
    @(negedge CLK);
    check("waiting_wait", BUS_WAIT, 1);
    RST = 1'b1;
    BUS_REQ = 1'b0;
    tick(0);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_wait", BUS_WAIT, 0);
    check("rst_mid_dreq", DREQ, 1);
    check("rst_mid_full", SRC_FULL, 0);
    check("rst_mid_empty", SNK_EMPTY, 1);
    tick(0);
    ce_rand = 1'b1;
    repeat (400) begin
      SRC_WR = ($urandom_range(0, 3) == 0);
      SRC_DATA = $urandom;
      case ($urandom_range(0, 7))
        0, 1: push_src($urandom);
        2: pop_snk();
        3: access(2'($urandom), 1'($urandom), $urandom, 4'($urandom), 1, 1'($urandom));
        4: access(2'd0, 0, 0, 4'hf, 4, 1'($urandom));
        5: access(2'd1, 1, $urandom, 4'($urandom), 4, 1'($urandom));
        6: access(2'd3, 1, $urandom_range(0, 15), 4'($urandom), 1, 0);
        default: miss();
      endcase
      SRC_WR = 1'b0;
    end
    ce_rand = 1'b0;
    tick(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
